logger_record_arb: RTL and testbench



---
 rtl/logger_record_arb.sv | 149 ++++++++++++++
 tb/tb_logger_record_arb.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logger_record_arb.sv
// logger_record_arb
//   Round-robin arbiter and record sequencer in front of the logger byte FIFO.
//   One source is granted at a time and the grant is held until that source's
//   last byte is accepted, so records never interleave in the FIFO. A new
//   record may start only while the FIFO reports prog_full low; the FIFO
//   headroom above the prog_full threshold absorbs any legal-length record.
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   src_valid       per-source byte valid
//   src_data        per-source byte, source i on bits [8i+7:8i]
//   src_last        per-source last-byte-of-record flag (qualified by valid)
//   src_ready       per-source byte accept (combinational from grant and full)
//   fifo_wr_en      FIFO write strobe
//   fifo_din        FIFO write data (zero when not writing)
//   fifo_full       FIFO full
//   fifo_prog_full  FIFO programmable full, gates record starts only
//   busy            a record is in transfer
//   grant_idx       currently or most recently granted source
//   rec_count       completed records, wraps modulo 2^CNT_W
//   err_overlen     sticky: a record exceeded MAX_REC_LEN bytes
module logger_record_arb #(
  parameter int NUM_SRC     = 4,
  parameter int MAX_REC_LEN = 56,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [NUM_SRC*8-1:0]       src_data,
  input  logic [NUM_SRC-1:0]         src_last,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic                       fifo_wr_en,
  output logic [7:0]                 fifo_din,
  input  logic                       fifo_full,
  input  logic                       fifo_prog_full,
  output logic                       busy,
  output logic [$clog2(NUM_SRC)-1:0] grant_idx,
  output logic [CNT_W-1:0]           rec_count,
  output logic                       err_overlen
);

  localparam int GIDX_W = $clog2(NUM_SRC);
  localparam int LEN_W  = $clog2(MAX_REC_LEN + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t            state, state_nxt;
  logic [GIDX_W-1:0] grant_nxt;
  logic [LEN_W-1:0]  byte_cnt, byte_cnt_nxt;
  logic [CNT_W-1:0]  rec_count_nxt;
  logic              err_nxt;

  logic              pick_found;
  logic [GIDX_W-1:0] pick_idx;
  logic              accept;

  // The granted source's signals, selected once for the datapath.
  logic              g_valid;
  logic              g_last;
  logic [7:0]        g_data;

  assign g_valid = src_valid[grant_idx];
  assign g_last  = src_last[grant_idx];
  assign g_data  = src_data[8*int'(grant_idx) +: 8];

  assign busy = (state == XFER);

  // Round-robin pick: first valid source scanning upward from the one after
  // the last grant, wrapping modulo NUM_SRC (works for non-power-of-2 too).
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch, otherwise a path that skips the assignment infers a latch.
    pick_found = 1'b0;
    pick_idx   = grant_idx;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!pick_found && src_valid[(int'(grant_idx) + k) % NUM_SRC]) begin
        pick_found = 1'b1;
        pick_idx   = GIDX_W'((int'(grant_idx) + k) % NUM_SRC);
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_idx;
    byte_cnt_nxt  = byte_cnt;
    rec_count_nxt = rec_count;
    err_nxt       = err_overlen;
    src_ready     = '0;
    fifo_wr_en    = 1'b0;
    fifo_din      = 8'h00;
    accept        = 1'b0;

    case (state)
      IDLE: begin
        // Arbitration takes this whole cycle; no byte moves here.
        if (pick_found && !fifo_prog_full) begin
          grant_nxt    = pick_idx;
          byte_cnt_nxt = '0;
          state_nxt    = XFER;
        end
      end

      XFER: begin
        // prog_full is deliberately ignored here: the record was admitted
        // with enough headroom, only hard full stalls it.
        src_ready[grant_idx] = !fifo_full;
        accept               = g_valid && !fifo_full;
        fifo_wr_en           = accept;
        if (accept) begin
          fifo_din = g_data;
          if (byte_cnt != LEN_W'(MAX_REC_LEN))
            byte_cnt_nxt = byte_cnt + 1'b1;
          if (g_last) begin
            rec_count_nxt = rec_count + 1'b1;
            state_nxt     = IDLE;
          end else if (byte_cnt == LEN_W'(MAX_REC_LEN - 1)) begin
            // Byte MAX_REC_LEN is not the last one: flag it, keep streaming.
            err_nxt = 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only; rst_n is deliberately
  // absent from the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_idx   <= GIDX_W'(NUM_SRC - 1);
      byte_cnt    <= '0;
      rec_count   <= '0;
      err_overlen <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // values present before the edge.
      state       <= state_nxt;
      grant_idx   <= grant_nxt;
      byte_cnt    <= byte_cnt_nxt;
      rec_count   <= rec_count_nxt;
      err_overlen <= err_nxt;
    end
  end

endmodule

// File: tb/tb_logger_record_arb.sv
// tb_logger_record_arb
//   Directed scenarios plus a randomized phase. Each source holds a queue of
//   pending record bytes; a transaction-level model (current owner, round-
//   robin pointer, record length, completed count) predicts every output each
//   cycle and a scoreboard log records which source each FIFO byte came from.
module tb_logger_record_arb;

  localparam int NUM_SRC     = 4;
  localparam int MAX_REC_LEN = 6;
  localparam int CNT_W       = 4;
  localparam int GIDX_W      = $clog2(NUM_SRC);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_SRC-1:0]   src_valid;
  logic [NUM_SRC*8-1:0] src_data;
  logic [NUM_SRC-1:0]   src_last;
  logic [NUM_SRC-1:0]   src_ready;
  logic                 fifo_wr_en;
  logic [7:0]           fifo_din;
  logic                 fifo_full;
  logic                 fifo_prog_full;
  logic                 busy;
  logic [GIDX_W-1:0]    grant_idx;
  logic [CNT_W-1:0]     rec_count;
  logic                 err_overlen;

  logger_record_arb #(
    .NUM_SRC    (NUM_SRC),
    .MAX_REC_LEN(MAX_REC_LEN),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_last      (src_last),
    .src_ready     (src_ready),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_din      (fifo_din),
    .fifo_full     (fifo_full),
    .fifo_prog_full(fifo_prog_full),
    .busy          (busy),
    .grant_idx     (grant_idx),
    .rec_count     (rec_count),
    .err_overlen   (err_overlen)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pending record bytes per source.
  logic [7:0] q_data [NUM_SRC][$];
  bit         q_last [NUM_SRC][$];

  // Stimulus knobs, percentages 0..100.
  int valid_pct = 100;
  int full_pct  = 0;
  int pfull_pct = 0;

  // Reference model state.
  int               m_owner;   // -1 when no record is in progress
  int               m_ptr;     // last granted source
  int               m_len;     // bytes accepted in the current record
  logic [CNT_W-1:0] m_recs;
  bit               m_err;

  // Scoreboard of bytes written to the FIFO.
  int         log_src[$];
  logic [7:0] log_data[$];

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = NUM_SRC - 1;
    m_len   = 0;
    m_recs  = '0;
    m_err   = 1'b0;
  endtask

  task automatic clear_log();
    log_src.delete();
    log_data.delete();
  endtask

  task automatic add_record(input int s, input int len, input int base);
    for (int k = 0; k < len; k++) begin
      q_data[s].push_back(base < 0 ? 8'($urandom) : 8'(base + k));
      q_last[s].push_back(k == len - 1);
    end
  endtask

  task automatic drive_inputs();
    bit v;
    for (int i = 0; i < NUM_SRC; i++) begin
      v = (q_data[i].size() != 0) && ($urandom_range(99) < valid_pct);
      src_valid[i]      = v;
      src_data[8*i +: 8] = v ? q_data[i][0] : 8'($urandom);
      src_last[i]       = v ? q_last[i][0] : 1'($urandom);
    end
    fifo_full      = ($urandom_range(99) < full_pct);
    fifo_prog_full = ($urandom_range(99) < pfull_pct);
  endtask

  // One clock: check outputs at the falling edge against the model, advance
  // the model, then drive fresh inputs just after the rising edge.
  task automatic step();
    logic [NUM_SRC-1:0] exp_ready;
    logic               exp_wr;
    logic [7:0]         exp_din;
    bit                 last;
    logic [7:0]         d;
    int                 s;
    @(negedge clk);
    exp_ready = '0;
    exp_wr    = 1'b0;
    exp_din   = 8'h00;
    if (m_owner >= 0) begin
      exp_ready[m_owner] = !fifo_full;
      exp_wr             = src_valid[m_owner] && !fifo_full;
      if (exp_wr) exp_din = src_data[8*m_owner +: 8];
    end
    check("src_ready",   32'(src_ready),   32'(exp_ready));
    check("fifo_wr_en",  32'(fifo_wr_en),  32'(exp_wr));
    check("fifo_din",    32'(fifo_din),    32'(exp_din));
    check("busy",        32'(busy),        32'(m_owner >= 0));
    check("grant_idx",   32'(grant_idx),   32'(m_ptr));
    check("rec_count",   32'(rec_count),   32'(m_recs));
    check("err_overlen", 32'(err_overlen), 32'(m_err));

    if (!rst_n) begin
      model_reset();
    end else if (m_owner < 0) begin
      if (!fifo_prog_full) begin
        for (int k = 1; k <= NUM_SRC; k++) begin
          s = (m_ptr + k) % NUM_SRC;
          if (m_owner < 0 && src_valid[s]) begin
            m_owner = s;
            m_len   = 0;
          end
        end
        if (m_owner >= 0) m_ptr = m_owner;
      end
    end else if (exp_wr) begin
      d    = q_data[m_owner].pop_front();
      last = q_last[m_owner].pop_front();
      log_src.push_back(m_owner);
      log_data.push_back(d);
      m_len++;
      if (last) begin
        m_recs++;
        m_owner = -1;
      end else if (m_len == MAX_REC_LEN) begin
        m_err = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  function automatic int pending();
    int n = (m_owner >= 0) ? 1 : 0;
    for (int i = 0; i < NUM_SRC; i++) n += q_data[i].size();
    return n;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_pending", 32'(pending()), 32'd0);
  endtask

  task automatic wait_bytes(input int count, input int budget);
    int n = 0;
    while (log_data.size() < count && n < budget) begin
      step();
      n++;
    end
    check("wait_bytes", 32'(log_data.size()), 32'(count));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      q_data[i].delete();
      q_last[i].delete();
    end
    src_valid = '0;
    step();
    rst_n = 1'b1;
    check("rst_busy",  32'(busy),        32'd0);
    check("rst_grant", 32'(grant_idx),   32'(NUM_SRC - 1));
    check("rst_count", 32'(rec_count),   32'd0);
    check("rst_err",   32'(err_overlen), 32'd0);
    check("rst_ready", 32'(src_ready),   32'd0);
    check("rst_wr",    32'(fifo_wr_en),  32'd0);
  endtask

  task automatic check_order(input string tag, input int exp_src[$]);
    check({tag, "_len"}, 32'(log_src.size()), 32'(exp_src.size()));
    for (int k = 0; k < exp_src.size() && k < log_src.size(); k++)
      check({tag, "_src"}, 32'(log_src[k]), 32'(exp_src[k]));
  endtask

  int order[$];
  int n0;

  initial begin
    rst_n          = 1'b0;
    src_valid      = '0;
    src_data       = '0;
    src_last       = '0;
    fifo_full      = 1'b0;
    fifo_prog_full = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single 3-byte record from source 0.
    clear_log();
    add_record(0, 3, 'hA1);
    drain(50);
    for (int k = 0; k < 3 && k < log_data.size(); k++)
      check("s1_byte", 32'(log_data[k]), 32'(8'hA1 + k));
    check("s1_count", 32'(rec_count), 32'd1);
    check("s1_busy",  32'(busy),      32'd0);

    // Three simultaneous requesters from reset, then a round from source 3.
    do_reset();
    clear_log();
    add_record(0, 2, 'h10);
    add_record(1, 2, 'h20);
    add_record(3, 2, 'h30);
    drain(50);
    order = '{0, 0, 1, 1, 3, 3};
    check_order("s2a", order);
    clear_log();
    add_record(3, 2, 'h38);
    add_record(0, 2, 'h08);
    drain(50);
    order = '{0, 0, 3, 3};
    check_order("s2b", order);

    // prog_full blocks a record start from source 2.
    pfull_pct = 100;
    add_record(2, 2, 'h50);
    repeat (10) step();
    check("s3_busy",  32'(busy),      32'd0);
    check("s3_grant", 32'(grant_idx), 32'd3);
    pfull_pct = 0;
    step();
    step();
    check("s3_grant_after", 32'(grant_idx), 32'd2);
    check("s3_busy_after",  32'(busy),      32'd1);
    drain(50);

    // Three full cycles in the middle of a 5-byte record.
    clear_log();
    add_record(1, 5, 'h60);
    wait_bytes(2, 20);
    full_pct = 100;
    step();
    n0 = log_data.size();
    step();
    step();
    full_pct = 0;
    step();
    check("s4_stall", 32'(log_data.size()), 32'(n0));
    drain(50);
    check("s4_len", 32'(log_data.size()), 32'd5);
    for (int k = 0; k < 5 && k < log_data.size(); k++)
      check("s4_byte", 32'(log_data[k]), 32'(8'h60 + k));

    // Exactly MAX_REC_LEN bytes is legal; one longer record sets the flag.
    add_record(3, MAX_REC_LEN, 'h80);
    drain(50);
    check("s5_exact", 32'(err_overlen), 32'd0);
    clear_log();
    add_record(1, MAX_REC_LEN + 2, 'h70);
    drain(50);
    check("s5_len", 32'(log_data.size()), 32'(MAX_REC_LEN + 2));
    check("s5_err", 32'(err_overlen), 32'd1);
    add_record(2, 3, -1);
    drain(50);
    check("s5_sticky", 32'(err_overlen), 32'd1);

    // Reset in the middle of a record; source 0 wins the next arbitration.
    clear_log();
    add_record(2, 5, 'h90);
    wait_bytes(2, 20);
    do_reset();
    clear_log();
    add_record(3, 2, 'hC0);
    add_record(0, 2, 'hB0);
    drain(50);
    order = '{0, 0, 3, 3};
    check_order("s6", order);

    // Randomized traffic with stalls, valid gaps and counter wrap.
    valid_pct = 70;
    full_pct  = 20;
    pfull_pct = 15;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(9) == 0) begin
        int s = int'($urandom_range(NUM_SRC - 1));
        if (q_data[s].size() < 20)
          add_record(s, int'($urandom_range(MAX_REC_LEN + 2, 1)), -1);
      end
      step();
    end
    valid_pct = 100;
    full_pct  = 0;
    pfull_pct = 0;
    drain(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
